// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   start, flush     : request and abort strobes (core -> unit)
//   op, op_A, op_B   : funct3 operation code and rs1/rs2 operands (core -> unit)
//   result           : final value, held until the next accepted start (unit -> core)
//   zero_flag        : result == 0 (unit -> core)
//   busy             : iterative operation in flight (unit -> core)
//   done             : one-cycle pulse, result valid (unit -> core)
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] op_A;
  logic [XLEN-1:0] op_B;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            busy;
  logic            done;

  modport master (
    output start, flush, op, op_A, op_B,
    input  result, zero_flag, busy, done
  );

  modport slave (
    input  start, flush, op, op_A, op_B,
    output result, zero_flag, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, XLEN-parametrised.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_if.slave (start/flush/op/op_A/op_B in; result/zero_flag/busy/done out)
// Operands are reduced to magnitudes, processed unsigned (shift-add multiply,
// restoring divide, one bit per cycle) and the sign is reapplied on exit.
// Divide-by-zero and signed overflow bypass the iteration and finish in one step.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// 2*XLEN multiplier and skip the CALC state; divides are unaffected.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [2:0]        op_r;
  logic [CW-1:0]     cnt_r;
  logic [2*XLEN-1:0] acc_r;      // multiply: {hi, lo/multiplier}; divide: {remainder, quotient}
  logic [XLEN-1:0]   opnd_r;     // multiplicand or divisor magnitude
  logic              neg_lo_r;   // negate product / quotient on exit
  logic              neg_hi_r;   // negate remainder on exit
  logic [XLEN-1:0]   result_r;
  logic              done_r;
  logic              busy_r;

  logic              a_signed_s;
  logic              b_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              div_by_zero_s;
  logic              div_ovf_s;

  // Classify the incoming request: operand signedness, magnitudes, fast-path cases.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s = a_signed_s & bus.op_A[XLEN-1];
    b_neg_s = b_signed_s & bus.op_B[XLEN-1];
    if (a_neg_s) begin
      mag_a_s = -bus.op_A;
    end else begin
      mag_a_s = bus.op_A;
    end
    if (b_neg_s) begin
      mag_b_s = -bus.op_B;
    end else begin
      mag_b_s = bus.op_B;
    end
    div_by_zero_s = bus.op[2] & (bus.op_B == ZERO);
    // Only the signed divides (DIV/REM) can overflow.
    div_ovf_s = bus.op[2] & b_signed_s & (bus.op_A == MOST_NEG) & (bus.op_B == ALL_ONES);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;

  // Single-cycle unsigned product of the operand magnitudes.
  always_comb begin
    fast_prod_s = {ZERO, mag_a_s} * {ZERO, mag_b_s};
  end
`endif

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_trial_s;
  logic [2*XLEN-1:0] acc_next_s;

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, ZERO};
    div_trial_s = {1'b0, ZERO};
    if (op_r[2]) begin
      // Shifted partial remainder needs XLEN+1 bits before the trial subtract.
      div_trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opnd_r};
      if (!div_trial_s[XLEN]) begin
        acc_next_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_next_s = {acc_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
      end else begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
      end
      // Carry out of the add becomes the new MSB as the accumulator shifts right.
      acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_s;

  // Reapply signs and pick the half the operation returns.
  always_comb begin
    if (neg_lo_r) begin
      prod_s = -acc_r;
      quo_s  = -acc_r[XLEN-1:0];
    end else begin
      prod_s = acc_r;
      quo_s  = acc_r[XLEN-1:0];
    end
    if (neg_hi_r) begin
      rem_s = -acc_r[2*XLEN-1:XLEN];
    end else begin
      rem_s = acc_r[2*XLEN-1:XLEN];
    end
    case (op_r)
      3'b000:                 final_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_s = quo_s;
      3'b110, 3'b111:         final_s = rem_s;
      default:                final_s = ZERO;
    endcase
  end

  // Control FSM with registered result/done/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      op_r     <= 3'b000;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {ZERO, ZERO};
      opnd_r   <= ZERO;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      result_r <= ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_r  <= bus.op;
            cnt_r <= {CW{1'b0}};
            if (div_by_zero_s) begin
              acc_r    <= {bus.op_A, ALL_ONES};
              neg_lo_r <= 1'b0;
              neg_hi_r <= 1'b0;
              state_r  <= S_DONE;
            end else if (div_ovf_s) begin
              acc_r    <= {ZERO, bus.op_A};
              neg_lo_r <= 1'b0;
              neg_hi_r <= 1'b0;
              state_r  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!bus.op[2]) begin
              acc_r    <= fast_prod_s;
              neg_lo_r <= a_neg_s ^ b_neg_s;
              neg_hi_r <= a_neg_s;
              state_r  <= S_DONE;
`endif
            end else if (bus.op[2]) begin
              acc_r    <= {ZERO, mag_a_s};
              opnd_r   <= mag_b_s;
              neg_lo_r <= a_neg_s ^ b_neg_s;
              neg_hi_r <= a_neg_s;
              busy_r   <= 1'b1;
              state_r  <= S_CALC;
            end else begin
              acc_r    <= {ZERO, mag_b_s};
              opnd_r   <= mag_a_s;
              neg_lo_r <= a_neg_s ^ b_neg_s;
              neg_hi_r <= a_neg_s;
              busy_r   <= 1'b1;
              state_r  <= S_CALC;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              busy_r  <= 1'b0;
              state_r <= S_DONE;
            end else begin
              state_r <= S_CALC;
            end
          end
        end
        S_DONE: begin
          if (bus.flush) begin
            state_r <= S_IDLE;
          end else begin
            result_r <= final_s;
            done_r   <= 1'b1;
            state_r  <= S_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.result    = result_r;
  assign bus.zero_flag = (result_r == ZERO);
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference result from RV32M arithmetic rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as32, bs32, q;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    as32 = a;
    bs32 = b;
    r = 32'd0;
    case (op)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin q = as32 / bs32; r = q; end
      end
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin q = as32 % bs32; r = q; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Expected edges from the accepting edge to the done cycle.
  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Issue one request and observe (no checking here).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic zf, output int lat,
                       output int busy_cyc, output logic overlap, output logic done_after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.op_A = a; bus.op_B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_A = $urandom; bus.op_B = $urandom;
    lat = -1; busy_cyc = 0; overlap = 1'b0; res = 32'd0; zf = 1'b0; done_after = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        lat = n; res = bus.result; zf = bus.zero_flag;
        break;
      end
    end
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected %h", bus.result, 32'd0); end
    checks++; if (bus.zero_flag !== 1'b1) begin failures++; $display("FAIL reset_zero_flag: got %b expected 1", bus.zero_flag); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [12] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110,
                               3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] t_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_r  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    logic zf, ov, da;
    int lat, bc, el;
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], res, zf, lat, bc, ov, da);
      el = exp_latency(t_op[i], t_a[i], t_b[i]);
      checks++; if (res !== t_r[i]) begin failures++; $display("FAIL dir_result[%0d]: got %h expected %h", i, res, t_r[i]); end
      checks++; if (zf !== (t_r[i] == 32'd0)) begin failures++; $display("FAIL dir_zero_flag[%0d]: got %b expected %b", i, zf, (t_r[i] == 32'd0)); end
      checks++; if (lat != el) begin failures++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, el); end
      checks++; if (bc != ((el == 1) ? 0 : XLEN)) begin failures++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bc, (el == 1) ? 0 : XLEN); end
      checks++; if (ov !== 1'b0 || da !== 1'b0) begin failures++; $display("FAIL dir_done_shape[%0d]: overlap %b done_after %b expected 0 0", i, ov, da); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp_r;
    logic zf, ov, da;
    int lat, bc, el;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      do_op(op, a, b, res, zf, lat, bc, ov, da);
      exp_r = ref_model(op, a, b);
      el = exp_latency(op, a, b);
      checks++; if (res !== exp_r) begin failures++; $display("FAIL rnd_result op=%0d a=%h b=%h: got %h expected %h", op, a, b, res, exp_r); end
      checks++; if (lat != el) begin failures++; $display("FAIL rnd_latency op=%0d: got %0d expected %0d", op, lat, el); end
      checks++; if (bc != ((el == 1) ? 0 : XLEN) || ov !== 1'b0) begin failures++; $display("FAIL rnd_busy op=%0d: busy_cycles %0d overlap %b expected %0d 0", op, bc, ov, (el == 1) ? 0 : XLEN); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    logic zf, ov, da, seen_done;
    int lat, bc, n;
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.op_A = $urandom; bus.op_B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bc = 0;
    for (n = 0; n < 20 && bc < 10; n++) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    checks++; if (bc != 10) begin failures++; $display("FAIL flush_reach_calc: got %0d busy cycles expected 10", bc); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_idle: got busy %b expected 0", bus.busy); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL flush_no_done: got %b expected 0", seen_done); end
    checks++; if (bus.result !== prev) begin failures++; $display("FAIL flush_result_kept: got %h expected %h", bus.result, prev); end
    do_op(3'b101, 32'd9, 32'd3, res, zf, lat, bc, ov, da);
    checks++; if (res !== 32'd3) begin failures++; $display("FAIL flush_next_divu: got %h expected %h", res, 32'd3); end
    checks++; if (lat != XLEN + 1) begin failures++; $display("FAIL flush_next_latency: got %0d expected %0d", lat, XLEN + 1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, exp1, exp2;
    int lat, el;
    a1 = $urandom; b1 = $urandom | 32'd1;
    a2 = $urandom; b2 = $urandom;
    exp1 = ref_model(3'b111, a1, b1);
    exp2 = ref_model(3'b011, a2, b2);
    el = exp_latency(3'b011, a2, b2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b111; bus.op_A = a1; bus.op_B = b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
    checks++; if (lat != XLEN + 1 || bus.result !== exp1) begin failures++; $display("FAIL b2b_first: latency %0d result %h expected %0d %h", lat, bus.result, XLEN + 1, exp1); end
    // Still in the done cycle: issue the next request immediately.
    bus.start = 1'b1; bus.op = 3'b011; bus.op_A = a2; bus.op_B = b2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
    checks++; if (lat != el) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat, el); end
    checks++; if (bus.result !== exp2) begin failures++; $display("FAIL b2b_result: got %h expected %h", bus.result, exp2); end
  endtask

  task automatic test_ignored_start();
    logic [31:0] res;
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.op_A = 32'd1000; bus.op_B = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
    bus.start = 1'b1; bus.op = 3'b000; bus.op_A = 32'd5; bus.op_B = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; res = 32'd0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done) begin dones++; res = bus.result; end
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL ign_single_done: got %0d expected 1", dones); end
    checks++; if (res !== 32'd333) begin failures++; $display("FAIL ign_result: got %h expected %h", res, 32'd333); end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.op_A = $urandom; bus.op_B = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.result === 32'd0) begin failures++; $display("FAIL rstmid_pre: busy %b result %h expected busy 1 and nonzero result", bus.busy, bus.result); end
    rst = 1'b1;
    #1;
    checks++; if (bus.result !== 32'd0 || bus.zero_flag !== 1'b1) begin failures++; $display("FAIL rstmid_result: got %h zf %b expected 0 1", bus.result, bus.zero_flag); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_flags: busy %b done %b expected 0 0", bus.busy, bus.done); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rstmid_quiet: got activity %b expected 0", seen_done); end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000; bus.op_A = 32'd0; bus.op_B = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
